// File: rtl/hpu_regf_period_arbiter_if.sv
// Request/grant bundle between the PE request logic and the regfile period arbiter.
interface hpu_regf_period_arbiter_if #(
    parameter int CH_NB    = 3,
    parameter int PERIOD_W = 8,
    parameter int CH_IDX_W = (CH_NB > 1) ? $clog2(CH_NB) : 1
);
    logic [CH_NB-1:0]          req_vld;
    logic [CH_NB-1:0]          req_rdy;
    logic [CH_NB*PERIOD_W-1:0] period;
    logic                      prio_mode;
    logic                      gnt_vld;
    logic [CH_IDX_W-1:0]       gnt_id;
    logic [CH_NB-1:0]          busy;

    modport master (
        output req_vld, period, prio_mode,
        input  req_rdy, gnt_vld, gnt_id, busy
    );

    modport slave (
        input  req_vld, period, prio_mode,
        output req_rdy, gnt_vld, gnt_id, busy
    );
endinterface

// File: rtl/hpu_regf_period_arbiter.sv
// Regfile access arbiter: one grant per cycle, per-channel minimum grant period
// enforced by a down-counter, round-robin or fixed-priority selection.
module hpu_regf_period_arbiter #(
    parameter int CH_NB    = 3,
    parameter int PERIOD_W = 8,
    parameter int CH_IDX_W = (CH_NB > 1) ? $clog2(CH_NB) : 1
) (
    input  logic                      clk,
    input  logic                      s_rst,
    hpu_regf_period_arbiter_if.slave  bus
);
    logic [CH_NB-1:0][PERIOD_W-1:0] r_cnt;
    logic [CH_NB-1:0][PERIOD_W-1:0] w_cnt_nxt;
    logic [CH_IDX_W-1:0]            r_rr_ptr;
    logic [CH_IDX_W-1:0]            w_rr_nxt;
    logic                           r_gnt_vld_p1;
    logic [CH_IDX_W-1:0]            r_gnt_id_p1;
    logic [CH_NB-1:0]               r_busy_p1;
    logic [CH_NB-1:0]               w_busy_nxt;
    logic [CH_NB-1:0]               w_elig;
    logic [CH_NB-1:0]               w_gnt;
    logic                           w_sel_vld;
    logic [CH_IDX_W-1:0]            w_sel_id;
    logic [PERIOD_W-1:0]            w_per;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < CH_NB; i++) begin
            w_elig[i] = bus.req_vld[i] & (r_cnt[i] == '0);
        end
    end

    // Scan from the highest offset down so the lowest offset (closest to the
    // pointer, or lowest index in fixed-priority mode) wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_sel_vld = 1'b0;
        w_sel_id  = '0;
        for (int j = CH_NB - 1; j >= 0; j--) begin
            if (bus.prio_mode) begin
                idx = j;
            end else begin
                idx = int'(r_rr_ptr) + j;
                if (idx >= CH_NB) idx = idx - CH_NB;
            end
            if (w_elig[idx]) begin
                w_sel_vld = 1'b1;
                w_sel_id  = CH_IDX_W'(idx);
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_sel_vld && !s_rst) w_gnt[w_sel_id] = 1'b1;
    end

    assign bus.req_rdy = w_gnt;

    always_comb begin
        w_per      = '0;
        w_cnt_nxt  = '0;
        w_busy_nxt = '0;
        for (int i = 0; i < CH_NB; i++) begin
            w_per = bus.period[i*PERIOD_W +: PERIOD_W];
            if (w_gnt[i]) begin
                w_cnt_nxt[i] = (w_per == '0) ? '0 : w_per - 1'b1;
            end else if (r_cnt[i] != '0) begin
                w_cnt_nxt[i] = r_cnt[i] - 1'b1;
            end
            w_busy_nxt[i] = |w_cnt_nxt[i];
        end
    end

    assign w_rr_nxt = (w_sel_id == CH_IDX_W'(CH_NB - 1)) ? '0 : w_sel_id + 1'b1;

    // Stage p1: counters, round-robin pointer and registered grant outputs.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_cnt        <= '0;
            r_rr_ptr     <= '0;
            r_gnt_vld_p1 <= 1'b0;
            r_gnt_id_p1  <= '0;
            r_busy_p1    <= '0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_busy_p1    <= w_busy_nxt;
            r_gnt_vld_p1 <= |w_gnt;
            if (|w_gnt) begin
                r_gnt_id_p1 <= w_sel_id;
                r_rr_ptr    <= w_rr_nxt;
            end
        end
    end

    assign bus.gnt_vld = r_gnt_vld_p1;
    assign bus.gnt_id  = r_gnt_id_p1;
    assign bus.busy    = r_busy_p1;
endmodule
